// File: rtl/i2c_reg_read_master.sv
// i2c_reg_read_master
//   Single-master I2C controller performing one register read:
//   START, {dev_addr,W}, ACK, reg_addr, ACK, RESTART, {dev_addr,R}, ACK,
//   8 data bits, master NACK, STOP.
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; bus released, scl high
//   START | start condition (sda falls while scl high)
//   WADDR | send {dev_addr,0}, MSB first
//   ACK1  | slave ACK slot after write address
//   WREG  | send reg_addr
//   ACK2  | slave ACK slot after register byte
//   RSTART| repeated start
//   RADDR | send {dev_addr,1}
//   ACK3  | slave ACK slot after read address
//   RDATA | receive 8 data bits, sda released
//   MNACK | master NACK (sda released)
//   STOP  | stop condition (sda rises while scl high)
//   DONE  | one-cycle completion pulse
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     read request, accepted only in IDLE
//   dev_addr  7-bit slave address, captured on accept
//   reg_addr  register address, captured on accept
//   busy      high from accept through the done cycle
//   done      one-cycle end-of-transaction pulse
//   ack_err   some slave ACK slot was sampled high; held until next accept
//   rd_data   byte read, updated only on error-free completion
//   scl       I2C clock, push-pull
//   sda       I2C data, open-drain (driven 0 or released)
module i2c_reg_read_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data,
    output logic       scl,
    inout  wire        sda
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WADDR, S_ACK1, S_WREG, S_ACK2, S_RSTART,
        S_RADDR, S_ACK3, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitcnt;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [7:0]    rx_sh;
    logic          tick_q;
    logic          end_period;
    logic          sample_pt;
    logic          byte_state;
    logic          ack_state;
    logic          sda_low;
    logic [7:0]    tx_byte;

    assign tick_q     = (qcnt == QW'(CLK_DIV - 1));
    assign end_period = tick_q && (q == 2'd3);
    // Sample on the last cycle of q2, i.e. just before scl has been high for half its time.
    assign sample_pt  = tick_q && (q == 2'd2);
    assign byte_state = (state == S_WADDR) || (state == S_WREG) ||
                        (state == S_RADDR) || (state == S_RDATA);
    assign ack_state  = (state == S_ACK1) || (state == S_ACK2) || (state == S_ACK3);

    // Open-drain pad: never drive a 1.
    assign sda = sda_low ? 1'b0 : 1'bz;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_START;
            S_START:  if (end_period) state_nxt = S_WADDR;
            S_WADDR:  if (end_period && bitcnt == 3'd7) state_nxt = S_ACK1;
            S_ACK1:   if (end_period) state_nxt = ack_err ? S_STOP : S_WREG;
            S_WREG:   if (end_period && bitcnt == 3'd7) state_nxt = S_ACK2;
            S_ACK2:   if (end_period) state_nxt = ack_err ? S_STOP : S_RSTART;
            S_RSTART: if (end_period) state_nxt = S_RADDR;
            S_RADDR:  if (end_period && bitcnt == 3'd7) state_nxt = S_ACK3;
            S_ACK3:   if (end_period) state_nxt = ack_err ? S_STOP : S_RDATA;
            S_RDATA:  if (end_period && bitcnt == 3'd7) state_nxt = S_MNACK;
            S_MNACK:  if (end_period) state_nxt = S_STOP;
            S_STOP:   if (end_period) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_WADDR: tx_byte = {dev_q, 1'b0};
            S_WREG:  tx_byte = reg_q;
            S_RADDR: tx_byte = {dev_q, 1'b1};
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        case (state)
            S_START: sda_low = q[1];
            S_WADDR, S_WREG, S_RADDR: begin
                scl     = q[1];
                sda_low = ~tx_byte[3'd7 - bitcnt];
            end
            S_ACK1, S_ACK2, S_ACK3, S_RDATA, S_MNACK: scl = q[1];
            S_RSTART: begin
                scl     = (q != 2'd0);
                sda_low = (q == 2'd3);
            end
            S_STOP: begin
                scl     = (q != 2'd0);
                sda_low = ~q[1];
            end
            default: ;
        endcase
    end

    // Timing counters and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt    <= '0;
            q       <= 2'd0;
            bitcnt  <= 3'd0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            rx_sh   <= 8'd0;
            ack_err <= 1'b0;
            rd_data <= 8'h00;
        end else if (state == S_IDLE) begin
            qcnt   <= '0;
            q      <= 2'd0;
            bitcnt <= 3'd0;
            if (start) begin
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                ack_err <= 1'b0;
            end
        end else begin
            if (tick_q) begin
                qcnt <= '0;
                q    <= q + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
            // 3-bit counter wraps 7->0 at each byte boundary.
            if (end_period && byte_state) bitcnt <= bitcnt + 3'd1;
            if (sample_pt && ack_state && sda) ack_err <= 1'b1;
            if (sample_pt && state == S_RDATA) rx_sh <= {rx_sh[6:0], sda};
            if (state == S_STOP && end_period && !ack_err) rd_data <= rx_sh;
        end
    end

endmodule
